// File: rtl/modn_counter_display_if.sv
// Control and display bundle of the modulo-N counter: the master drives controls,
// the counter (slave) returns count, terminal count and the scanned segment/anode pins.
interface modn_counter_display_if #(
   parameter int DIGITS = 4
);
   logic                  en;
   logic                  up;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic                  clr;
   logic [4*DIGITS-1:0]   count;
   logic                  tc;
   logic [6:0]            seg;
   logic [DIGITS-1:0]     an;

   modport master (
      output en, up, load, load_val, clr,
      input  count, tc, seg, an
   );

   modport slave (
      input  en, up, load, load_val, clr,
      output count, tc, seg, an
   );
endinterface

// File: rtl/modn_counter_display.sv
// Cascaded DIGITS-digit modulo-MOD up/down counter with a free-running scan that
// drives a multiplexed 7-segment display from the same registered count.
module modn_counter_display #(
   parameter int DIGITS         = 4,
   parameter int MOD            = 10,
   parameter int SCAN_DIV       = 1000,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   modn_counter_display_if.slave bus
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [3:0]        MAXD    = 4'(MOD - 1);
   localparam logic [PW-1:0]     PLAST   = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]     ILAST   = IW'(DIGITS - 1);
   localparam logic [6:0]        RST_SEG = (SEG_ACTIVE_LOW != 0) ? ~7'h3F : 7'h3F;
   localparam logic [DIGITS-1:0] RST_AN  = (SEG_ACTIVE_LOW != 0) ? ~DIGITS'(1) : DIGITS'(1);

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'h0:    glyph = 7'h3F;
         4'h1:    glyph = 7'h06;
         4'h2:    glyph = 7'h5B;
         4'h3:    glyph = 7'h4F;
         4'h4:    glyph = 7'h66;
         4'h5:    glyph = 7'h6D;
         4'h6:    glyph = 7'h7D;
         4'h7:    glyph = 7'h07;
         4'h8:    glyph = 7'h7F;
         4'h9:    glyph = 7'h6F;
         4'hA:    glyph = 7'h77;
         4'hB:    glyph = 7'h7C;
         4'hC:    glyph = 7'h39;
         4'hD:    glyph = 7'h5E;
         4'hE:    glyph = 7'h79;
         4'hF:    glyph = 7'h71;
         default: glyph = 7'h00;
      endcase
   endfunction

   logic [4*DIGITS-1:0] count_r;
   logic                tc_r;
   logic [PW-1:0]       presc_r;
   logic [IW-1:0]       idx_r;
   logic [6:0]          seg_r;
   logic [DIGITS-1:0]   an_r;

   logic [4*DIGITS-1:0] count_nxt_s;
   logic                tc_nxt_s;
   logic                carry_s;
   logic [PW-1:0]       presc_nxt_s;
   logic [IW-1:0]       idx_nxt_s;
   logic [3:0]          sel_digit_s;
   logic [6:0]          seg_nxt_s;
   logic [DIGITS-1:0]   an_nxt_s;

   // Next count: clr beats load beats en; carry/borrow ripples through all digits in one cycle.
   always_comb begin
      count_nxt_s = count_r;
      tc_nxt_s    = 1'b0;
      carry_s     = 1'b1;
      if (bus.clr) begin
         count_nxt_s = '0;
      end else if (bus.load) begin
         for (int k = 0; k < DIGITS; k++) begin
            if (bus.load_val[4*k +: 4] > MAXD) begin
               count_nxt_s[4*k +: 4] = MAXD;
            end else begin
               count_nxt_s[4*k +: 4] = bus.load_val[4*k +: 4];
            end
         end
      end else if (bus.en) begin
         for (int k = 0; k < DIGITS; k++) begin
            if (!carry_s) begin
               count_nxt_s[4*k +: 4] = count_r[4*k +: 4];
            end else if (bus.up) begin
               if (count_r[4*k +: 4] == MAXD) begin
                  count_nxt_s[4*k +: 4] = 4'd0;
               end else begin
                  count_nxt_s[4*k +: 4] = count_r[4*k +: 4] + 4'd1;
                  carry_s               = 1'b0;
               end
            end else begin
               if (count_r[4*k +: 4] == 4'd0) begin
                  count_nxt_s[4*k +: 4] = MAXD;
               end else begin
                  count_nxt_s[4*k +: 4] = count_r[4*k +: 4] - 4'd1;
                  carry_s               = 1'b0;
               end
            end
         end
         // A carry surviving the top digit means every digit wrapped together.
         tc_nxt_s = carry_s;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Scan prescaler and digit index; display pins are built from next-state values so they never lag count.
   always_comb begin
      if (presc_r == PLAST) begin
         presc_nxt_s = '0;
         if (idx_r == ILAST) begin
            idx_nxt_s = '0;
         end else begin
            idx_nxt_s = idx_r + IW'(1);
         end
      end else begin
         presc_nxt_s = presc_r + PW'(1);
         idx_nxt_s   = idx_r;
      end
      sel_digit_s = count_nxt_s[{idx_nxt_s, 2'b00} +: 4];
      if (SEG_ACTIVE_LOW != 0) begin
         seg_nxt_s = ~glyph(sel_digit_s);
         an_nxt_s  = ~(DIGITS'(1) << idx_nxt_s);
      end else begin
         seg_nxt_s = glyph(sel_digit_s);
         an_nxt_s  = DIGITS'(1) << idx_nxt_s;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
         tc_r    <= 1'b0;
         presc_r <= '0;
         idx_r   <= '0;
         seg_r   <= RST_SEG;
         an_r    <= RST_AN;
      end else begin
         count_r <= count_nxt_s;
         tc_r    <= tc_nxt_s;
         presc_r <= presc_nxt_s;
         idx_r   <= idx_nxt_s;
         seg_r   <= seg_nxt_s;
         an_r    <= an_nxt_s;
      end
   end

   assign bus.count = count_r;
   assign bus.tc    = tc_r;
   assign bus.seg   = seg_r;
   assign bus.an    = an_r;
endmodule

// File: tb/tb_modn_counter_display.sv
// Directed bench for modn_counter_display: a BCD 4-digit active-low instance and a
// hex 2-digit active-high instance, with expectations queued before each edge.
module tb_modn_counter_display;
   logic clk;
   logic rst_na;
   logic rst_nb;
   int   checks = 0;
   int   errors = 0;

   string       tag_q[$];
   logic [31:0] exp_q[$];

   logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] seg_tab [4] = '{7'h19, 7'h30, 7'h24, 7'h79};

   modn_counter_display_if #(.DIGITS(4)) ia ();
   modn_counter_display_if #(.DIGITS(2)) ib ();

   modn_counter_display #(.DIGITS(4), .MOD(10), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) dut_a (
      .clk(clk), .rst_n(rst_na), .bus(ia.slave)
   );
   modn_counter_display #(.DIGITS(2), .MOD(16), .SCAN_DIV(1), .SEG_ACTIVE_LOW(0)) dut_b (
      .clk(clk), .rst_n(rst_nb), .bus(ib.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic expect_val(input string tag, input logic [31:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic check_next(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
   endtask

   task automatic step_a(input logic en_v, input logic up_v, input logic ld_v, input logic clr_v,
                         input logic [15:0] lv, input logic [15:0] ec, input logic et, input string tag);
      ia.en = en_v; ia.up = up_v; ia.load = ld_v; ia.clr = clr_v; ia.load_val = lv;
      expect_val({tag, "_count"}, 32'(ec));
      expect_val({tag, "_tc"}, 32'(et));
      @(posedge clk);
      #1;
      check_next(32'(ia.count));
      check_next(32'(ia.tc));
   endtask

   task automatic step_b(input logic en_v, input logic up_v, input logic ld_v, input logic [7:0] lv,
                         input logic [7:0] ec, input logic et, input logic [6:0] es,
                         input logic [1:0] ean, input string tag);
      ib.en = en_v; ib.up = up_v; ib.load = ld_v; ib.clr = 1'b0; ib.load_val = lv;
      expect_val({tag, "_count"}, 32'(ec));
      expect_val({tag, "_tc"}, 32'(et));
      expect_val({tag, "_seg"}, 32'(es));
      expect_val({tag, "_an"}, 32'(ean));
      @(posedge clk);
      #1;
      check_next(32'(ib.count));
      check_next(32'(ib.tc));
      check_next(32'(ib.seg));
      check_next(32'(ib.an));
   endtask

   initial begin
      rst_na = 1'b0; rst_nb = 1'b0;
      ia.en = 1'b0; ia.up = 1'b0; ia.load = 1'b0; ia.clr = 1'b0; ia.load_val = '0;
      ib.en = 1'b0; ib.up = 1'b0; ib.load = 1'b0; ib.clr = 1'b0; ib.load_val = '0;

      // Reset state of the BCD instance.
      repeat (2) @(posedge clk);
      #1;
      expect_val("rst_count", 32'h0);
      expect_val("rst_tc", 32'h0);
      expect_val("rst_an", 32'he);
      expect_val("rst_seg", 32'h40);
      check_next(32'(ia.count));
      check_next(32'(ia.tc));
      check_next(32'(ia.an));
      check_next(32'(ia.seg));

      // Scan: load 1234 on the first edge after release, then watch 16 edges.
      @(negedge clk);
      rst_na = 1'b1;
      ia.load_val = 16'h1234;
      for (int n = 1; n <= 16; n++) begin
         ia.load = (n == 1);
         expect_val("scan_count", 32'h1234);
         expect_val("scan_an", 32'(an_tab[(n / 4) % 4]));
         expect_val("scan_seg", 32'(seg_tab[(n / 4) % 4]));
         @(posedge clk);
         #1;
         check_next(32'(ia.count));
         check_next(32'(ia.an));
         check_next(32'(ia.seg));
      end

      // Carry ripple and full up wrap.
      step_a(1'b0, 1'b1, 1'b1, 1'b0, 16'h0999, 16'h0999, 1'b0, "ld0999");
      step_a(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h1000, 1'b0, "ripple");
      step_a(1'b0, 1'b1, 1'b1, 1'b0, 16'h9999, 16'h9999, 1'b0, "ld9999");
      step_a(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, "upwrap");
      step_a(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, "tc_width");

      // Down wrap.
      step_a(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, "ld0000");
      step_a(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1, "dnwrap");
      step_a(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9998, 1'b0, "dnstep");

      // Saturating load and priority.
      step_a(1'b0, 1'b0, 1'b1, 1'b0, 16'h12F4, 16'h1294, 1'b0, "ldsat");
      step_a(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555, 16'h0000, 1'b0, "clr_wins");
      step_a(1'b1, 1'b1, 1'b1, 1'b0, 16'h0042, 16'h0042, 1'b0, "ld_wins");
      step_a(1'b0, 1'b1, 1'b0, 1'b0, 16'h0777, 16'h0042, 1'b0, "hold");

      // Continuous enable and per-cycle direction changes around the wrap.
      step_a(1'b0, 1'b1, 1'b1, 1'b0, 16'h9998, 16'h9998, 1'b0, "ld9998");
      step_a(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0, "run0");
      step_a(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, "run1");
      step_a(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, "run2");
      step_a(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, "dir0");
      step_a(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1, "dir1");
      step_a(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, "dir2");

      // Asynchronous reset between edges with a count held.
      step_a(1'b0, 1'b1, 1'b1, 1'b0, 16'h0537, 16'h0537, 1'b0, "ld0537");
      step_a(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0537, 1'b0, "hold0537");
      #2;
      rst_na = 1'b0;
      #1;
      expect_val("arst_count", 32'h0);
      expect_val("arst_tc", 32'h0);
      expect_val("arst_an", 32'he);
      expect_val("arst_seg", 32'h40);
      check_next(32'(ia.count));
      check_next(32'(ia.tc));
      check_next(32'(ia.an));
      check_next(32'(ia.seg));

      // Hex instance, scan every clock, active-high pins.
      @(negedge clk);
      rst_nb = 1'b1;
      step_b(1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 7'h71, 2'b10, "hex_ldff");
      step_b(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 7'h3F, 2'b01, "hex_wrap");
      step_b(1'b0, 1'b1, 1'b1, 8'hAB, 8'hAB, 1'b0, 7'h77, 2'b10, "hex_ab_hi");
      step_b(1'b0, 1'b1, 1'b0, 8'h00, 8'hAB, 1'b0, 7'h7C, 2'b01, "hex_ab_lo");
      step_b(1'b1, 1'b0, 1'b0, 8'h00, 8'hAA, 1'b0, 7'h77, 2'b10, "hex_dn");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
